// File: rtl/mult_div_ctrl.sv
// Iterative signed Booth multiplier / restoring divider with its own sequencer.
// Multiply takes WIDTH+1 cycles to done, divide WIDTH+2, divide-by-zero 1; starts are ignored while busy.
module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mult_hi,
  output logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo,
  output logic             div_mult,
  output logic             hi_write,
  output logic             lo_write,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE, DZERO} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  // {acc, q, q_-1}; acc carries one guard bit so -2^(W-1) multiplicands cannot overflow
  logic [2*WIDTH+1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               sign_a;
  logic               sign_b;

  logic [WIDTH:0]     mcand_ext;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH+1:0] prod_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic               last_step;

  always_comb begin
    mcand_ext = {mcand[WIDTH-1], mcand};
    booth_sum = prod[2*WIDTH+1:WIDTH+1];
    case (prod[1:0])
      2'b01:   booth_sum = prod[2*WIDTH+1:WIDTH+1] + mcand_ext;
      2'b10:   booth_sum = prod[2*WIDTH+1:WIDTH+1] - mcand_ext;
      default: booth_sum = prod[2*WIDTH+1:WIDTH+1];
    endcase
    prod_nxt = {booth_sum[WIDTH], booth_sum, prod[WIDTH:1]};

    rem_sh = {rem, quo[WIDTH-1]};
    if (rem_sh >= {1'b0, dvs}) begin
      rem_nxt = WIDTH'(rem_sh - {1'b0, dvs});
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end

    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mult_hi  <= '0;
      mult_lo  <= '0;
      div_hi   <= '0;
      div_lo   <= '0;
      div_mult <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            mcand <= op_a;
            prod  <= {{(WIDTH+1){1'b0}}, op_b, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MULT;
          end else if (start_div) begin
            busy <= 1'b1;
            if (op_b == '0) begin
              div_zero <= 1'b1;
              state    <= DZERO;
            end else begin
              sign_a <= op_a[WIDTH-1];
              sign_b <= op_b[WIDTH-1];
              quo    <= op_a[WIDTH-1] ? -op_a : op_a;
              dvs    <= op_b[WIDTH-1] ? -op_b : op_b;
              rem    <= '0;
              cnt    <= '0;
              state  <= DIV;
            end
          end
        end
        MULT: begin
          prod <= prod_nxt;
          if (last_step) begin
            mult_hi  <= prod_nxt[2*WIDTH:WIDTH+1];
            mult_lo  <= prod_nxt[WIDTH:1];
            div_mult <= 1'b1;
            done     <= 1'b1;
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (last_step) state <= FIX;
          else           cnt   <= cnt + 1'b1;
        end
        FIX: begin
          // truncating division: remainder takes the dividend's sign
          div_lo   <= (sign_a ^ sign_b) ? -quo : quo;
          div_hi   <= sign_a ? -rem : rem;
          div_mult <= 1'b0;
          done     <= 1'b1;
          hi_write <= 1'b1;
          lo_write <= 1'b1;
          state    <= DONE;
        end
        DONE, DZERO: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: stimulus pushes expected completions, a negedge monitor checks them.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_mult;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .div_mult(div_mult), .hi_write(hi_write),
    .lo_write(lo_write), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dz;
    logic        dm;
    logic [31:0] mh, ml, dh, dl;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_mh = 0, m_ml = 0, m_dh = 0, m_dl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (done || div_zero || hi_write || lo_write)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: done=%0b dz=%0b hw=%0b lw=%0b (cyc %0d)",
                 done, div_zero, hi_write, lo_write, cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("done", {31'b0, done}, {31'b0, !e.dz});
        chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        chk("hi_write", {31'b0, hi_write}, {31'b0, !e.dz});
        chk("lo_write", {31'b0, lo_write}, {31'b0, !e.dz});
        if (!e.dz) chk("div_mult", {31'b0, div_mult}, {31'b0, e.dm});
        chk("mult_hi", mult_hi, e.mh);
        chk("mult_lo", mult_lo, e.ml);
        chk("div_hi", div_hi, e.dh);
        chk("div_lo", div_lo, e.dl);
      end
    end
  end

  // Drives one start request for a cycle; optionally records the expected completion.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] rh, input logic [31:0] rl);
    exp_t x;
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a = a;
    op_b = b;
    if (push) begin
      x.dz = d && !m && (b == 0);
      x.dm = m;
      if (m) begin
        m_mh = rh;
        m_ml = rl;
      end else if (!x.dz) begin
        m_dh = rh;
        m_dl = rl;
      end
      x.mh = m_mh; x.ml = m_ml; x.dh = m_dh; x.dl = m_dl;
      x.cyc = cyc + (x.dz ? 1 : (m ? 33 : 34));
      sb.push_back(x);
    end
    @(negedge clk);
    start_mult = 0;
    start_div  = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d completions outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1; start_mult = 0; start_div = 0; op_a = 0; op_b = 0;
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_flags", {26'b0, done, div_zero, hi_write, lo_write, div_mult, busy}, 0);
    chk("rst_res", mult_hi | mult_lo | div_hi | div_lo, 0);
    @(negedge clk);
    reset = 0;

    issue(1, 0, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB); wait_drain();
    issue(1, 0, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0); wait_drain();
    issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 32'h1); wait_drain();
    issue(0, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD); wait_drain();
    issue(0, 1, 32'd100, 32'hFFFFFFF9, 1, 32'd2, 32'hFFFFFFF2); wait_drain();
    issue(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1, 32'hFFFFFFFE, 32'd14); wait_drain();
    issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000); wait_drain();
    issue(0, 1, 32'd123, 32'd0, 1, 32'h0, 32'h0); wait_drain();

    // Both starts together, then a stray divide request mid-multiply.
    issue(1, 1, 32'd3, 32'd5, 1, 32'h0, 32'd15);
    repeat (3) @(negedge clk);
    start_div = 1;
    op_b = 0;
    @(negedge clk);
    start_div = 0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Reset during a multiply: abort with no completion.
    issue(1, 0, 32'd9, 32'd9, 0, 32'h0, 32'h0);
    repeat (8) @(negedge clk);
    reset = 1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_flags", {26'b0, done, div_zero, hi_write, lo_write, div_mult, busy}, 0);
    chk("abort_res", mult_hi | mult_lo | div_hi | div_lo, 0);
    m_mh = 0; m_ml = 0; m_dh = 0; m_dl = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);

    issue(1, 0, 32'h12345678, 32'h10, 1, 32'h1, 32'h23456780); wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
